// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: state encodings shared by the key debouncer files.
// DBNC_REPEAT_EN (see key_debounce.sv) does not change these encodings.
package key_debounce_pkg;

    localparam int unsigned DBNC_STATE_W = 2;

    typedef enum logic [DBNC_STATE_W-1:0] {
        DBNC_IDLE_S       = 2'd0,
        DBNC_WAIT_PRESS_S = 2'd1,
        DBNC_HELD_S       = 2'd2,
        DBNC_WAIT_REL_S   = 2'd3
    } dbnc_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: key pin, timer handshake and debounced key events.
// master = debouncer side, slave = pin/timer/consumer side.
interface key_debounce_if;

    logic KEY_RAW;
    logic TMR_DONE;
    logic START_TMR;
    logic KEY_LEVEL;
    logic PRESS;
    logic RELEASE;

    modport master (
        input  KEY_RAW, TMR_DONE,
        output START_TMR, KEY_LEVEL, PRESS, RELEASE
    );

    modport slave (
        output KEY_RAW, TMR_DONE,
        input  START_TMR, KEY_LEVEL, PRESS, RELEASE
    );

endinterface

// File: rtl/key_debounce_key_sync.sv
// key_sync: SYNC_STAGES-deep synchronizer for the raw key pin, then polarity
// normalisation so key_s = 1 means pressed. Flops reset to the released level.
module key_sync #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic KEY_RAW,
    output logic key_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= KEY_ACTIVE_LOW ? '1 : '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], KEY_RAW};
        end
    end

    assign key_s = sync_q[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: timer-windowed debouncer producing a clean level plus PRESS/RELEASE.
// Optional build macro DBNC_REPEAT_EN adds auto-repeat PRESS every REPEAT_TICKS windows.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          KEY_ACTIVE_LOW = 1'b1,
    parameter int unsigned REPEAT_TICKS   = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    key_debounce_if.master dbnc
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("REPEAT_TICKS must be at least 1");
    end

    dbnc_state_e state;
    logic        key_s;
    logic        tmr_busy;
    logic        win_own;     // outstanding timer was started for the current window
    logic        start_tmr;
    logic        level_q;
    logic        press_q;
    logic        release_q;

`ifdef DBNC_REPEAT_EN
    localparam int unsigned CNT_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    logic [CNT_W-1:0] rpt_cnt;
`endif

    key_sync #(
        .SYNC_STAGES   (SYNC_STAGES),
        .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_key_sync (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .KEY_RAW(dbnc.KEY_RAW),
        .key_s  (key_s)
    );

    // START_TMR must be combinational: the timer only accepts a start while idle or
    // in its own pulse cycle, so restarts have to coincide with TMR_DONE.
    always_comb begin
        start_tmr = 1'b0;
        case (state)
            DBNC_WAIT_PRESS_S, DBNC_WAIT_REL_S:
                start_tmr = !win_own && (!tmr_busy || dbnc.TMR_DONE);
            DBNC_HELD_S: begin
`ifdef DBNC_REPEAT_EN
                start_tmr = !tmr_busy || dbnc.TMR_DONE;
`else
                start_tmr = !key_s && (!tmr_busy || dbnc.TMR_DONE);
`endif
            end
            default: start_tmr = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= DBNC_IDLE_S;
            tmr_busy  <= 1'b0;
            win_own   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef DBNC_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (start_tmr) begin
                tmr_busy <= 1'b1;
            end else if (dbnc.TMR_DONE) begin
                tmr_busy <= 1'b0;
            end

            case (state)
                DBNC_IDLE_S: begin
                    if (key_s) begin
                        state   <= DBNC_WAIT_PRESS_S;
                        win_own <= 1'b0;
                    end
                end
                DBNC_WAIT_PRESS_S: begin
                    if (win_own && dbnc.TMR_DONE) begin
                        if (key_s) begin
                            state   <= DBNC_HELD_S;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
`ifdef DBNC_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else begin
                            state <= DBNC_IDLE_S;
                        end
                    end else if (start_tmr) begin
                        win_own <= 1'b1;
                    end
                end
                DBNC_HELD_S: begin
                    // A start issued in the release cycle belongs to the release window.
                    if (!key_s) begin
                        state   <= DBNC_WAIT_REL_S;
                        win_own <= start_tmr;
                    end
`ifdef DBNC_REPEAT_EN
                    else if (dbnc.TMR_DONE) begin
                        if (rpt_cnt == CNT_W'(REPEAT_TICKS - 1)) begin
                            press_q <= 1'b1;
                            rpt_cnt <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
`endif
                end
                DBNC_WAIT_REL_S: begin
                    if (win_own && dbnc.TMR_DONE) begin
                        if (!key_s) begin
                            state     <= DBNC_IDLE_S;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            state <= DBNC_HELD_S;
`ifdef DBNC_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end
                    end else if (start_tmr) begin
                        win_own <= 1'b1;
                    end
                end
                default: begin
                    state     <= DBNC_IDLE_S;
                    win_own   <= 1'b0;
                    level_q   <= 1'b0;
                    press_q   <= 1'b0;
                    release_q <= 1'b0;
                end
            endcase
        end
    end

    assign dbnc.START_TMR = start_tmr;
    assign dbnc.KEY_LEVEL = level_q;
    assign dbnc.PRESS     = press_q;
    assign dbnc.RELEASE   = release_q;

endmodule
